// File: rtl/prog_counter_if.sv
// Control/status bundle for prog_counter: the driver (master) owns the strobes and
// operands, the counter (slave) owns the count and flags.
interface prog_counter_if #(
  parameter int WIDTH = 20
);
  logic             clr;
  logic             en;
  logic             up_dn;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             flag_clr;
  logic [WIDTH-1:0] cmp_val;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             ovf;
  logic             cmp_match;

  modport master (
    output clr, en, up_dn, load, load_val, flag_clr, cmp_val,
    input  q, tc, ovf, cmp_match
  );

  modport slave (
    input  clr, en, up_dn, load, load_val, flag_clr, cmp_val,
    output q, tc, ovf, cmp_match
  );
endinterface

// File: rtl/prog_counter.sv
// Parametrised up/down modulo counter with enable prescaler, parallel load,
// wrap/saturate terminal behaviour, terminal-count pulse, sticky overflow and compare.
module prog_counter #(
  parameter int unsigned      WIDTH    = 20,
  parameter longint unsigned  MAX_VAL  = (64'd1 << WIDTH) - 64'd1,
  parameter int unsigned      PRESCALE = 1,
  parameter bit               SATURATE = 1'b0
) (
  input  logic          clk,
  input  logic          sclr_n,
  prog_counter_if.slave bus
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]    PS_LAST = PW'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] MAX_Q   = MAX_VAL[WIDTH-1:0];

  generate
    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
      $error("prog_counter: WIDTH must be in 2..32");
    end
    if (MAX_VAL > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_max
      $error("prog_counter: MAX_VAL exceeds 2**WIDTH-1");
    end
    if (PRESCALE == 0 || PRESCALE > 65535) begin : g_bad_prescale
      $error("prog_counter: PRESCALE must be in 1..65535");
    end
  endgenerate

  logic [WIDTH-1:0] q_q, q_d;
  logic [PW-1:0]    ps_q, ps_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             tick;

  // Priority: clr > load > tick > hold; a terminal tick sets ovf even against flag_clr.
  always_comb begin
    q_d   = q_q;
    ps_d  = ps_q;
    tc_d  = 1'b0;
    ovf_d = ovf_q & ~bus.flag_clr;
    tick  = bus.en && (ps_q == PS_LAST);

    if (bus.clr) begin
      q_d  = '0;
      ps_d = '0;
    end else if (bus.load) begin
      q_d  = (bus.load_val > MAX_Q) ? MAX_Q : bus.load_val;
      ps_d = '0;
    end else if (tick) begin
      ps_d = '0;
      if (bus.up_dn) begin
        if (q_q < MAX_Q) begin
          q_d = q_q + WIDTH'(1);
        end else begin
          q_d   = SATURATE ? MAX_Q : '0;
          tc_d  = 1'b1;
          ovf_d = 1'b1;
        end
      end else begin
        if (q_q > '0) begin
          q_d = q_q - WIDTH'(1);
        end else begin
          q_d   = SATURATE ? '0 : MAX_Q;
          tc_d  = 1'b1;
          ovf_d = 1'b1;
        end
      end
    end else if (bus.en) begin
      ps_d = ps_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!sclr_n) begin
      q_q   <= '0;
      ps_q  <= '0;
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      ps_q  <= ps_d;
      tc_q  <= tc_d;
      ovf_q <= ovf_d;
    end
  end

  assign bus.q         = q_q;
  assign bus.tc        = tc_q;
  assign bus.ovf       = ovf_q;
  assign bus.cmp_match = (q_q == bus.cmp_val);

endmodule
